// File: rtl/ttt_pkg.sv
// Shared tic-tac-toe definitions: cell encoding, board size, controller states
// and the flat board indexing helper.
package ttt_pkg;
  localparam logic [1:0] EMPTY   = 2'd0;
  localparam logic [1:0] P1      = 2'd1;
  localparam logic [1:0] P2      = 2'd2;
  localparam int         BOARD_N = 3;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_MOVE = 2'd1,
    CHECK     = 2'd2,
    GAME_OVER = 2'd3
  } state_t;

  // Cell (r,c) occupies board bits [2*idx+1 : 2*idx].
  function automatic int cell_idx(input int r, input int c);
    return BOARD_N * r + c;
  endfunction
endpackage

// File: rtl/ttt_win_check.sv
// Combinational line detector: flags any row, column or diagonal fully owned
// by the given player.
module ttt_win_check
  import ttt_pkg::*;
(
  input  logic [17:0] board,
  input  logic [1:0]  player,
  output logic        line_found
);
  logic [8:0] own;

  genvar i;
  generate
    for (i = 0; i < 9; i++) begin : g_own
      assign own[i] = (board[2*i +: 2] == player);
    end
  endgenerate

  assign line_found = (&own[2:0]) | (&own[5:3]) | (&own[8:6]) |
                      (own[0] & own[3] & own[6]) |
                      (own[1] & own[4] & own[7]) |
                      (own[2] & own[5] & own[8]) |
                      (own[0] & own[4] & own[8]) |
                      (own[2] & own[4] & own[6]);
endmodule

// File: rtl/ttt_turn_ctrl.sv
// Two-player tic-tac-toe turn controller: arbitrates moves, enforces the
// per-turn deadline and judges win/draw after every accepted move.
module ttt_turn_ctrl
  import ttt_pkg::*;
#(
  parameter int TURN_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        new_game,
  input  logic        p1_req,
  input  logic [2:0]  p1_x,
  input  logic [2:0]  p1_y,
  input  logic        p2_req,
  input  logic [2:0]  p2_x,
  input  logic [2:0]  p2_y,
  output logic        p1_ack,
  output logic        p1_rej,
  output logic        p2_ack,
  output logic        p2_rej,
  output logic [1:0]  turn,
  output logic [1:0]  winner,
  output logic        stop_game,
  output logic        draw,
  output logic        timeout,
  output logic [3:0]  move_count,
  output logic [17:0] board
);
  localparam int            TW     = $clog2(TURN_TIMEOUT + 1);
  localparam logic [TW-1:0] T_LOAD = TW'(TURN_TIMEOUT);

  state_t        state, state_n;
  logic [17:0]   board_n;
  logic [3:0]    cnt_n;
  logic [1:0]    turn_n, winner_n, other;
  logic          draw_n;
  logic [TW-1:0] timer, timer_n;
  logic          p1_ack_n, p1_rej_n, p2_ack_n, p2_rej_n, timeout_n;
  logic          sel_req, coords_ok, occupied, legal, line_found;
  logic [2:0]    sel_x, sel_y;
  logic [3:0]    cidx;

  ttt_win_check u_win (
    .board      (board),
    .player     (turn),
    .line_found (line_found)
  );

  // Only the side to move is ever looked at.
  assign sel_req   = (turn == P1) ? p1_req : p2_req;
  assign sel_x     = (turn == P1) ? p1_x   : p2_x;
  assign sel_y     = (turn == P1) ? p2_y_or(p1_y) : p2_y;
  assign coords_ok = (sel_x <= 3'd2) && (sel_y <= 3'd2);
  assign cidx      = 4'(cell_idx(int'(sel_x[1:0]), int'(sel_y[1:0])));
  assign other     = (turn == P1) ? P2 : P1;
  assign legal     = coords_ok && !occupied;
  assign stop_game = (state == GAME_OVER);

  function automatic logic [2:0] p2_y_or(input logic [2:0] y);
    return y;
  endfunction

  always_comb begin
    occupied = 1'b0;
    for (int i = 0; i < 9; i++)
      if (coords_ok && 4'(i) == cidx && board[2*i +: 2] != EMPTY) occupied = 1'b1;
  end

  always_comb begin
    state_n   = state;
    board_n   = board;
    cnt_n     = move_count;
    turn_n    = turn;
    winner_n  = winner;
    draw_n    = draw;
    timer_n   = timer;
    p1_ack_n  = 1'b0;
    p1_rej_n  = 1'b0;
    p2_ack_n  = 1'b0;
    p2_rej_n  = 1'b0;
    timeout_n = 1'b0;
    if (new_game) begin
      state_n  = WAIT_MOVE;
      board_n  = '0;
      cnt_n    = '0;
      turn_n   = P1;
      winner_n = EMPTY;
      draw_n   = 1'b0;
      timer_n  = T_LOAD;
    end else begin
      case (state)
        WAIT_MOVE: if (enable) begin
          if (sel_req && legal) begin
            for (int i = 0; i < 9; i++)
              if (4'(i) == cidx) board_n[2*i +: 2] = turn;
            cnt_n    = move_count + 4'd1;
            p1_ack_n = (turn == P1);
            p2_ack_n = (turn == P2);
            state_n  = CHECK;
          end else if (sel_req) begin
            // A request on the expiry edge beats the timeout, so hold at 1.
            p1_rej_n = (turn == P1);
            p2_rej_n = (turn == P2);
            if (timer > TW'(1)) timer_n = timer - TW'(1);
          end else if (timer == TW'(1)) begin
            timeout_n = 1'b1;
            turn_n    = other;
            timer_n   = T_LOAD;
          end else begin
            timer_n = timer - TW'(1);
          end
        end
        CHECK: begin
          if (line_found) begin
            winner_n = turn;
            turn_n   = EMPTY;
            state_n  = GAME_OVER;
          end else if (move_count == 4'd9) begin
            draw_n  = 1'b1;
            turn_n  = EMPTY;
            state_n = GAME_OVER;
          end else begin
            turn_n  = other;
            timer_n = T_LOAD;
            state_n = WAIT_MOVE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      board      <= '0;
      move_count <= '0;
      turn       <= EMPTY;
      winner     <= EMPTY;
      draw       <= 1'b0;
      timer      <= T_LOAD;
      p1_ack     <= 1'b0;
      p1_rej     <= 1'b0;
      p2_ack     <= 1'b0;
      p2_rej     <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state      <= state_n;
      board      <= board_n;
      move_count <= cnt_n;
      turn       <= turn_n;
      winner     <= winner_n;
      draw       <= draw_n;
      timer      <= timer_n;
      p1_ack     <= p1_ack_n;
      p1_rej     <= p1_rej_n;
      p2_ack     <= p2_ack_n;
      p2_rej     <= p2_rej_n;
      timeout    <= timeout_n;
    end
  end
endmodule

// File: tb/tb_ttt_turn_ctrl.sv
// Self-checking bench: directed game scenarios plus randomized play, all
// compared each cycle against a board-array reference model.
module tb_ttt_turn_ctrl;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n, enable, new_game;
  logic        p1_req, p2_req;
  logic [2:0]  p1_x, p1_y, p2_x, p2_y;
  logic        p1_ack, p1_rej, p2_ack, p2_rej, timeout, stop_game, draw;
  logic [1:0]  turn, winner;
  logic [3:0]  move_count;
  logic [17:0] board;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: phase 0 idle, 1 awaiting move, 2 judging, 3 finished.
  int       mb[3][3];
  int       m_phase, m_turn, m_win, m_cnt, m_timer;
  bit       m_draw;
  logic [4:0] m_pulse;

  ttt_turn_ctrl #(.TURN_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .new_game(new_game),
    .p1_req(p1_req), .p1_x(p1_x), .p1_y(p1_y),
    .p2_req(p2_req), .p2_x(p2_x), .p2_y(p2_y),
    .p1_ack(p1_ack), .p1_rej(p1_rej), .p2_ack(p2_ack), .p2_rej(p2_rej),
    .turn(turn), .winner(winner), .stop_game(stop_game), .draw(draw),
    .timeout(timeout), .move_count(move_count), .board(board)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic bit has_line(input int p);
    for (int k = 0; k < 3; k++) begin
      if (mb[k][0] == p && mb[k][1] == p && mb[k][2] == p) return 1'b1;
      if (mb[0][k] == p && mb[1][k] == p && mb[2][k] == p) return 1'b1;
    end
    if (mb[0][0] == p && mb[1][1] == p && mb[2][2] == p) return 1'b1;
    if (mb[0][2] == p && mb[1][1] == p && mb[2][0] == p) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_board();
    logic [31:0] v = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        v = v | (32'(mb[r][c]) << (2 * (3 * r + c)));
    return v;
  endfunction

  task automatic model_clear();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) mb[r][c] = 0;
    m_cnt = 0; m_win = 0; m_draw = 1'b0; m_timer = TO; m_pulse = '0;
  endtask

  task automatic model_reset();
    model_clear();
    m_phase = 0; m_turn = 0;
  endtask

  // Advance the model by one clock using the inputs the DUT is about to sample.
  task automatic model_step();
    int side, x, y;
    bit rq;
    m_pulse = '0;
    if (new_game) begin
      model_clear();
      m_phase = 1; m_turn = 1;
    end else if (m_phase == 1 && enable) begin
      side = m_turn;
      rq   = (side == 1) ? p1_req : p2_req;
      x    = (side == 1) ? int'(p1_x) : int'(p2_x);
      y    = (side == 1) ? int'(p1_y) : int'(p2_y);
      if (rq) begin
        if (x <= 2 && y <= 2 && mb[x % 3][y % 3] == 0) begin
          mb[x][y] = side; m_cnt++;
          m_pulse[(side == 1) ? 4 : 2] = 1'b1;
          m_phase = 2;
        end else begin
          m_pulse[(side == 1) ? 3 : 1] = 1'b1;
          if (m_timer > 1) m_timer--;
        end
      end else begin
        m_timer--;
        if (m_timer == 0) begin
          m_pulse[0] = 1'b1; m_turn = 3 - m_turn; m_timer = TO;
        end
      end
    end else if (m_phase == 2) begin
      if (has_line(m_turn)) begin
        m_win = m_turn; m_turn = 0; m_phase = 3;
      end else if (m_cnt == 9) begin
        m_draw = 1'b1; m_turn = 0; m_phase = 3;
      end else begin
        m_turn = 3 - m_turn; m_timer = TO; m_phase = 1;
      end
    end
  endtask

  task automatic compare();
    chk("board", 32'(board), m_board());
    chk("turn", 32'(turn), 32'(m_turn));
    chk("winner", 32'(winner), 32'(m_win));
    chk("draw", 32'(draw), 32'(m_draw));
    chk("stop_game", 32'(stop_game), 32'(m_phase == 3));
    chk("move_count", 32'(move_count), 32'(m_cnt));
    chk("pulses", 32'({p1_ack, p1_rej, p2_ack, p2_rej, timeout}), 32'(m_pulse));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic start_game();
    new_game = 1'b1; tick(); new_game = 1'b0;
  endtask

  task automatic do_move(input int side, input int x, input int y);
    if (side == 1) begin p1_req = 1'b1; p1_x = 3'(x); p1_y = 3'(y); end
    else           begin p2_req = 1'b1; p2_x = 3'(x); p2_y = 3'(y); end
    tick();
    chk("move_ack", 32'((side == 1) ? p1_ack : p2_ack), 32'd1);
    p1_req = 1'b0; p2_req = 1'b0;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b1; new_game = 1'b0;
    p1_req = 1'b0; p2_req = 1'b0;
    p1_x = '0; p1_y = '0; p2_x = '0; p2_y = '0;
    model_reset();
    @(posedge clk); #1;
    compare();
    chk("reset_turn", 32'(turn), 32'd0);
    rst_n = 1'b1;
    tick();  // idle: nothing happens

    // Row-0 win for player 1.
    start_game();
    chk("ng_turn", 32'(turn), 32'd1);
    do_move(1, 0, 0); do_move(2, 1, 0); do_move(1, 0, 1);
    do_move(2, 1, 1); do_move(1, 0, 2);
    chk("win_winner", 32'(winner), 32'd1);
    chk("win_stop", 32'(stop_game), 32'd1);
    chk("win_count", 32'(move_count), 32'd5);
    chk("win_turn", 32'(turn), 32'd0);
    p1_req = 1'b1; p1_x = 3'd2; p1_y = 3'd2;
    tick(); tick();  // requests ignored once finished
    p1_req = 1'b0;

    // Occupied cell and out-of-range coordinate rejections.
    start_game();
    do_move(1, 1, 1);
    p2_req = 1'b1; p2_x = 3'd1; p2_y = 3'd1;
    tick();
    chk("occ_rej", 32'(p2_rej), 32'd1);
    chk("occ_board", 32'(board), 32'h100);
    chk("occ_turn", 32'(turn), 32'd2);
    p2_x = 3'd3; p2_y = 3'd0;
    tick();
    chk("range_rej", 32'(p2_rej), 32'd1);
    p2_req = 1'b0;
    tick();

    // Full-board draw: X O X / X O O / O X X.
    start_game();
    do_move(1, 0, 0); do_move(2, 0, 1); do_move(1, 0, 2);
    do_move(2, 1, 1); do_move(1, 1, 0); do_move(2, 1, 2);
    do_move(1, 2, 1); do_move(2, 2, 0); do_move(1, 2, 2);
    chk("draw_flag", 32'(draw), 32'd1);
    chk("draw_winner", 32'(winner), 32'd0);
    chk("draw_count", 32'(move_count), 32'd9);

    // Timeout with an out-of-turn request pending.
    start_game();
    p2_req = 1'b1; p2_x = 3'd0; p2_y = 3'd0;
    repeat (3) tick();
    tick();
    chk("to_pulse", 32'(timeout), 32'd1);
    chk("to_turn", 32'(turn), 32'd2);
    chk("to_count", 32'(move_count), 32'd0);
    chk("to_p2_quiet", 32'({p2_ack, p2_rej}), 32'd0);
    p2_req = 1'b0;
    tick();

    // Freeze: request and timer held while enable is low.
    start_game();
    enable = 1'b0; p1_req = 1'b1; p1_x = 3'd0; p1_y = 3'd0;
    repeat (6) begin
      tick();
      chk("frz_quiet", 32'({p1_ack, timeout}), 32'd0);
    end
    enable = 1'b1;
    tick();
    chk("frz_ack", 32'(p1_ack), 32'd1);
    p1_req = 1'b0;
    tick();

    // Asynchronous reset between edges, then new_game beats a same-cycle request.
    p2_req = 1'b1; p2_x = 3'd2; p2_y = 3'd0;
    tick();
    p2_req = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_board", 32'(board), 32'd0);
    chk("arst_turn", 32'(turn), 32'd0);
    chk("arst_count", 32'(move_count), 32'd0);
    chk("arst_stop", 32'(stop_game), 32'd0);
    model_reset();
    #1 rst_n = 1'b1;
    new_game = 1'b1; p1_req = 1'b1; p1_x = 3'd2; p1_y = 3'd2;
    tick();
    chk("ng_req_board", 32'(board), 32'd0);
    chk("ng_req_ack", 32'(p1_ack), 32'd0);
    new_game = 1'b0; p1_req = 1'b0;

    // Randomized play; players hold requests until answered.
    for (int n = 0; n < 3000; n++) begin
      new_game = (m_phase == 0) || ($urandom_range(0, 59) == 0) ||
                 (m_phase == 3 && $urandom_range(0, 3) == 0);
      enable   = ($urandom_range(0, 9) != 0);
      tick();
      if (p1_ack || p1_rej) p1_req = 1'b0;
      else if (!p1_req && $urandom_range(0, 2) == 0) begin
        p1_req = 1'b1; p1_x = 3'($urandom_range(0, 3)); p1_y = 3'($urandom_range(0, 3));
      end
      if (p2_ack || p2_rej) p2_req = 1'b0;
      else if (!p2_req && $urandom_range(0, 2) == 0) begin
        p2_req = 1'b1; p2_x = 3'($urandom_range(0, 3)); p2_y = 3'($urandom_range(0, 3));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/ttt_turn_ctrl.md
TTT_TURN_CTRL -- requirements
Module: ttt_turn_ctrl

Interface
REQ-001 TURN_TIMEOUT, 255, per-turn move deadline in clk cycles (range 2..65535).
REQ-002 clk  in  1  single clock; all state changes on its rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 enable  in  1  1 = run; 0 = freeze (timer holds, requests ignored, no pulses).
REQ-005 new_game  in  1  synchronous command: clear board, start new game.
REQ-006 p1_req / p2_req  in  1  per-player move request, held until ack or rej.
REQ-007 p1_x, p1_y / p2_x, p2_y  in  3 each  requested cell row/column; legal 0..2.
REQ-008 p1_ack, p1_rej / p2_ack, p2_rej  out  1 each  one-cycle accept/reject pulses.
REQ-009 turn  out  2  side to move: 0 none, 1 player 1, 2 player 2.
REQ-010 winner  out  2  0 none, 1 player 1, 2 player 2.
REQ-011 stop_game  out  1  game finished (win or draw).
REQ-012 draw  out  1  game ended with full board, no line.
REQ-013 timeout  out  1  one-cycle pulse: current player forfeited the turn.
REQ-014 move_count  out  4  accepted moves this game, 0..9.
REQ-015 board  out  18  cell (r,c) at bits [2*(3r+c)+1 : 2*(3r+c)]; 0 empty, 1 P1, 2 P2.

Function
REQ-016 FSM states IDLE, WAIT_MOVE, CHECK, GAME_OVER; reset enters IDLE.
REQ-017 new_game in any state (enable don't-care): board=0, move_count=0, winner=0, draw=0, turn=1, timer=TURN_TIMEOUT, next state WAIT_MOVE; overrides any same-cycle request.
REQ-018 IDLE: turn=0; requests ignored, no ack/rej.
REQ-019 WAIT_MOVE, enable=1: only the req of the side named by turn is sampled; the other side's req gets no response.
REQ-020 Accepted move (coordinates <=2, cell empty): next edge writes cell=turn, move_count+1, ack pulse for the mover, state -> CHECK.
REQ-021 Illegal move (x>2, y>2 or cell occupied): rej pulse next edge; board, turn, state unchanged; timer keeps counting.
REQ-022 Mover SHALL drop req after ack/rej; a req still high in the next WAIT_MOVE of the same side is a new request.
REQ-023 CHECK (one cycle, no request sampling): any of 8 lines owned by mover -> winner=turn, stop_game=1, GAME_OVER; else move_count==9 -> draw=1, stop_game=1, GAME_OVER; else turn toggles 1<->2, timer reloaded, WAIT_MOVE.
REQ-024 Move latency: req sampled edge N -> ack and board update visible after N; turn toggle visible after N+1.
REQ-025 Timer decrements each WAIT_MOVE cycle with enable=1 and no accepted move; a request sampled on the expiry edge wins over timeout.
REQ-026 Timer expiry (reaching 0): timeout pulse, turn toggles, timer reloaded, move_count and board unchanged.
REQ-027 GAME_OVER: turn=0; board, winner, draw, move_count held; requests ignored; exit only via new_game or reset.
REQ-028 stop_game = 1 exactly in GAME_OVER.

Reset
REQ-029 reset low asynchronously forces IDLE, board=0, move_count=0, turn=0, winner=0, draw=0, stop_game=0, all pulses 0, timer=TURN_TIMEOUT.
REQ-030 Reset mid-game discards the game; release returns to IDLE awaiting new_game.

Structure
REQ-031 Package ttt_pkg holds cell encoding constants (EMPTY=0, P1=1, P2=2), BOARD_N=3, FSM state enum, board index function.
REQ-032 Sub-module ttt_win_check: combinational, board + player in, line_found out (3 rows, 3 columns, 2 diagonals).
REQ-033 Timer width = clog2(TURN_TIMEOUT+1).

Verification
REQ-034 new_game; P1 (0,0), P2 (1,0), P1 (0,1), P2 (1,1), P1 (0,2) -> five acks, winner=1, stop_game=1, move_count=5, turn=0.
REQ-035 P1 (1,1) accepted, then P2 (1,1) -> p2_rej one cycle, board unchanged, turn=2; P2 (3,0) -> p2_rej.
REQ-036 Nine-move no-line sequence (X O X / X O O / O X X order) -> draw=1, winner=0, move_count=9.
REQ-037 TURN_TIMEOUT=4, P1 idle -> timeout pulse 4 cycles into WAIT_MOVE, turn=2, move_count=0; p2_req during P1 turn -> no ack/rej.
REQ-038 reset low mid-game asynchronously (between edges) -> outputs zeroed immediately; new_game with p1_req (2,2) in same cycle -> board empty, no ack.
REQ-039 enable=0 during WAIT_MOVE with p1_req valid -> no ack, timer frozen; enable=1 -> ack next edge.
